// File: rtl/latency_ram_if.sv
// Request/response bundle for latency_ram: independent read and write channels.
// The wr_be signal exists only when RAM_BYTE_WR_EN is defined.
interface latency_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_busy;
  logic                  rd_done;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
`ifdef RAM_BYTE_WR_EN
  logic [DATA_W/8-1:0]   wr_be;
`endif
  logic                  wr_busy;
  logic                  wr_done;
  logic                  acc_err;

`ifdef RAM_BYTE_WR_EN
  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  input  rd_busy, rd_done, rd_data, wr_busy, wr_done, acc_err);
  modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  output rd_busy, rd_done, rd_data, wr_busy, wr_done, acc_err);
`else
  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data,
                  input  rd_busy, rd_done, rd_data, wr_busy, wr_done, acc_err);
  modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
                  output rd_busy, rd_done, rd_data, wr_busy, wr_done, acc_err);
`endif
endinterface

// File: rtl/latency_ram.sv
// Byte-addressed big-endian memory with fixed-latency read and write channels.
// Define RAM_BYTE_WR_EN to add per-byte write enables (wr_be).
module latency_ram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 64,
  parameter int RD_LAT      = 10,
  parameter int WR_LAT      = 10
) (
  input logic          clk,
  input logic          nRST,
  latency_ram_if.slave bus
);
  localparam int NB      = DATA_W / 8;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int IDX_W   = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  // End address is formed one bit wider so a high base cannot wrap into range.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] end_a;
    end_a = {1'b0, a} + (ADDR_W+1)'(NB);
    return end_a <= (ADDR_W+1)'(DEPTH_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] byte_idx(input logic [ADDR_W-1:0] a, input int i);
    return IDX_W'(a + ADDR_W'(i));
  endfunction

  logic [7:0] mem [DEPTH_BYTES];

  state_e              rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [NB-1:0]       wr_be_s;
  logic                rd_busy_q, rd_busy_d, wr_busy_q, wr_busy_d;
  logic                rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic                acc_err_q, acc_err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d, rd_word_s;
  logic                rd_fin_s, wr_fin_s, wr_commit_s;

`ifdef RAM_BYTE_WR_EN
  logic [NB-1:0]       wr_be_q;
  assign wr_be_s = wr_be_q;
`else
  assign wr_be_s = {NB{1'b1}};
`endif

  assign rd_fin_s    = (rd_state_q == WAIT) && (rd_cnt_q == {CNT_W{1'b0}});
  assign wr_fin_s    = (wr_state_q == WAIT) && (wr_cnt_q == {CNT_W{1'b0}});
  assign wr_commit_s = wr_fin_s && in_range(wr_addr_q);

  // State, counters, request latches and registered outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rd_state_q <= IDLE;
      wr_state_q <= IDLE;
      rd_cnt_q   <= {CNT_W{1'b0}};
      wr_cnt_q   <= {CNT_W{1'b0}};
      rd_addr_q  <= {ADDR_W{1'b0}};
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
`ifdef RAM_BYTE_WR_EN
      wr_be_q    <= {NB{1'b0}};
`endif
      rd_busy_q  <= 1'b0;
      wr_busy_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      acc_err_q  <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      if (rd_state_q == IDLE && bus.rd_req) begin
        rd_addr_q <= bus.rd_addr;
      end
      if (wr_state_q == IDLE && bus.wr_req) begin
        wr_addr_q <= bus.wr_addr;
        wr_data_q <= bus.wr_data;
`ifdef RAM_BYTE_WR_EN
        wr_be_q   <= bus.wr_be;
`endif
      end
      rd_busy_q  <= rd_busy_d;
      wr_busy_q  <= wr_busy_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
      acc_err_q  <= acc_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      IDLE: begin
        if (bus.rd_req) begin
          rd_state_d = WAIT;
          rd_cnt_d   = CNT_W'(RD_LAT - 1);
        end else begin
          rd_state_d = IDLE;
        end
      end
      WAIT: begin
        if (rd_cnt_q == {CNT_W{1'b0}}) begin
          rd_state_d = IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    case (wr_state_q)
      IDLE: begin
        if (bus.wr_req) begin
          wr_state_d = WAIT;
          wr_cnt_d   = CNT_W'(WR_LAT - 1);
        end else begin
          wr_state_d = IDLE;
        end
      end
      WAIT: begin
        if (wr_cnt_q == {CNT_W{1'b0}}) begin
          wr_state_d = IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q - CNT_W'(1);
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

  // Big-endian gather: byte at rd_addr lands in the word MSB
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      rd_word_s[DATA_W-1-8*i -: 8] = mem[byte_idx(rd_addr_q, i)];
    end
  end

  always_comb begin
    rd_busy_d = (rd_state_d == WAIT);
    wr_busy_d = (wr_state_d == WAIT);
    rd_done_d = rd_fin_s;
    wr_done_d = wr_fin_s;
    acc_err_d = (rd_fin_s && !in_range(rd_addr_q)) || (wr_fin_s && !in_range(wr_addr_q));
    if (rd_fin_s) begin
      rd_data_d = in_range(rd_addr_q) ? rd_word_s : {DATA_W{1'b0}};
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Array is never reset; a read finishing on this edge still sees the old bytes
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_s[NB-1-i]) begin
          mem[byte_idx(wr_addr_q, i)] <= wr_data_q[DATA_W-1-8*i -: 8];
        end
      end
    end
  end

  assign bus.rd_busy = rd_busy_q;
  assign bus.wr_busy = wr_busy_q;
  assign bus.rd_done = rd_done_q;
  assign bus.wr_done = wr_done_q;
  assign bus.acc_err = acc_err_q;
  assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_latency_ram.sv
// Directed bench for latency_ram with default parameters (64 bytes, latency 10).
module tb_latency_ram;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [31:0] rdv, rdv2;

  always #5 clk = ~clk;

  latency_ram_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  latency_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH_BYTES(64), .RD_LAT(LAT), .WR_LAT(LAT))
    dut (.clk(clk), .nRST(nRST), .bus(bus));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issues one write, scrambles the inputs after acceptance, waits for wr_done.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic exp_err);
    int k;
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
`ifdef RAM_BYTE_WR_EN
    bus.wr_be   = be;
`endif
    @(negedge clk);
    bus.wr_req  = 1'b0;
    bus.wr_addr = ~a;
    bus.wr_data = ~d;
`ifdef RAM_BYTE_WR_EN
    bus.wr_be   = ~be;
`endif
    check_eq("wr_busy", {31'd0, bus.wr_busy}, 32'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.wr_done && k < 40);
    check_eq("wr_lat", k, LAT);
    check_eq("wr_err", {31'd0, bus.acc_err}, {31'd0, exp_err});
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, input logic exp_err);
    int k;
    @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    bus.rd_req  = 1'b0;
    bus.rd_addr = ~a;
    check_eq("rd_busy", {31'd0, bus.rd_busy}, 32'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rd_done && k < 40);
    check_eq("rd_lat", k, LAT);
    check_eq("rd_err", {31'd0, bus.acc_err}, {31'd0, exp_err});
    d = bus.rd_data;
  endtask

  initial begin
    int ndone;
    int last;
    int k;
    bus.rd_req  = 1'b0;
    bus.rd_addr = 32'd0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = 32'd0;
    bus.wr_data = 32'd0;
`ifdef RAM_BYTE_WR_EN
    bus.wr_be   = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_rd_busy", {31'd0, bus.rd_busy}, 32'd0);
    check_eq("rst_wr_busy", {31'd0, bus.wr_busy}, 32'd0);
    check_eq("rst_rd_done", {31'd0, bus.rd_done}, 32'd0);
    check_eq("rst_wr_done", {31'd0, bus.wr_done}, 32'd0);
    check_eq("rst_acc_err", {31'd0, bus.acc_err}, 32'd0);
    check_eq("rst_rd_data", bus.rd_data, 32'd0);
    nRST = 1'b1;

    // Basic write/read, big-endian byte placement
    do_write(32'd4, 32'hDEADBEEF, 4'hF, 1'b0);
    do_read(32'd4, rdv, 1'b0);
    check_eq("rd4", rdv, 32'hDEADBEEF);
    do_read(32'd7, rdv, 1'b0);
    check_eq("rd7_msb", {24'd0, rdv[31:24]}, 32'h000000EF);

    // Held request: accepts every LAT+1 cycles
    @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'd4;
    @(negedge clk);
    ndone = 0;
    last  = 0;
    for (int c = 1; c <= 3 * (LAT + 1); c++) begin
      @(negedge clk);
      if (bus.rd_done) begin
        ndone++;
        last = c;
      end
    end
    bus.rd_req = 1'b0;
    check_eq("hold_ndone", ndone, 3);
    check_eq("hold_last", last, 2 * (LAT + 1) + LAT);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rd_done && k < 20);
    check_eq("hold_drain", k, LAT);
    check_eq("hold_data", bus.rd_data, 32'hDEADBEEF);

    // Same-edge collision returns old bytes
    do_write(32'd8, 32'hCAFEF00D, 4'hF, 1'b0);
    fork
      do_write(32'd8, 32'h11223344, 4'hF, 1'b0);
      do_read(32'd8, rdv, 1'b0);
    join
    check_eq("coll_old", rdv, 32'hCAFEF00D);
    do_read(32'd8, rdv, 1'b0);
    check_eq("coll_new", rdv, 32'h11223344);

    // Unaligned access
    do_write(32'd13, 32'hA1B2C3D4, 4'hF, 1'b0);
    do_read(32'd13, rdv, 1'b0);
    check_eq("unal13", rdv, 32'hA1B2C3D4);
    do_read(32'd14, rdv, 1'b0);
    check_eq("unal14", {rdv[31:8], 8'd0}, 32'hB2C3D400);

    // Range boundary and out-of-range accesses
    do_write(32'd60, 32'h01020304, 4'hF, 1'b0);
    do_read(32'd60, rdv, 1'b0);
    check_eq("edge60", rdv, 32'h01020304);
    do_read(32'd61, rdv, 1'b1);
    check_eq("oor_rd", rdv, 32'd0);
    do_write(32'd62, 32'h55555555, 4'hF, 1'b1);
    do_read(32'hFFFFFFFE, rdv, 1'b1);
    check_eq("oor_wrap", rdv, 32'd0);
    fork
      do_write(32'd62, 32'h66666666, 4'hF, 1'b1);
      do_read(32'd63, rdv2, 1'b1);
    join
    @(negedge clk);
    check_eq("err_pulse", {31'd0, bus.acc_err}, 32'd0);
    do_read(32'd60, rdv, 1'b0);
    check_eq("oor_untouched", rdv, 32'h01020304);

    // Reset in the middle of a write
    do_write(32'd0, 32'h12345678, 4'hF, 1'b0);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'd0;
    bus.wr_data = 32'h99999999;
`ifdef RAM_BYTE_WR_EN
    bus.wr_be   = 4'hF;
`endif
    @(negedge clk);
    bus.wr_req = 1'b0;
    repeat (4) @(negedge clk);
    nRST = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, bus.wr_busy}, 32'd0);
    check_eq("abort_done", {31'd0, bus.wr_done}, 32'd0);
    repeat (LAT) @(negedge clk);
    check_eq("abort_nodone", {31'd0, bus.wr_done}, 32'd0);
    nRST = 1'b1;
    do_read(32'd0, rdv, 1'b0);
    check_eq("abort_keep", rdv, 32'h12345678);

`ifdef RAM_BYTE_WR_EN
    do_write(32'd0, 32'hAABBCCDD, 4'b0101, 1'b0);
    do_read(32'd0, rdv, 1'b0);
    check_eq("byte_en", rdv, 32'h12BB56DD);
    do_write(32'd0, 32'hFFFFFFFF, 4'b0000, 1'b0);
    do_read(32'd0, rdv, 1'b0);
    check_eq("byte_en_none", rdv, 32'h12BB56DD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
